// File: rtl/demux8_4b_bank_pkg.sv
// rtl/demux8_4b_bank_pkg.sv - shared sizes and fill-state encoding for the slot bank
package demux8_4b_bank_pkg;

    localparam int SLOTS = 8;
    localparam int WIDTH = 4;
    localparam int PTR_W = 3;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fill_state_t;

    // Fill state is a pure function of the valid vector.
    function automatic fill_state_t state_from_valid(input logic [SLOTS-1:0] v);
        if (v == '0) begin
            return ST_EMPTY;
        end else if (&v) begin
            return ST_FULL;
        end else begin
            return ST_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/demux8_4b_bank_dec3to8.sv
// rtl/demux8_4b_bank_dec3to8.sv - 3-bit index to one-hot 8-bit write enable
module dec3to8
    import demux8_4b_bank_pkg::*;
(
    input  logic [PTR_W-1:0] idx,
    input  logic             en,
    output logic [SLOTS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux8_4b_bank.sv
// rtl/demux8_4b_bank.sv - eight 4-bit slots written by explicit select or by a streaming pointer
module demux8_4b_bank
    import demux8_4b_bank_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic [PTR_W-1:0] s,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             stream,
    input  logic             clear,
    output logic [WIDTH-1:0] w0,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] w3,
    output logic [WIDTH-1:0] w4,
    output logic [WIDTH-1:0] w5,
    output logic [WIDTH-1:0] w6,
    output logic [WIDTH-1:0] w7,
    output logic [SLOTS-1:0] valid,
    output logic [PTR_W-1:0] ptr,
    output logic             ready,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] slot_q [SLOTS];
    logic [SLOTS-1:0] valid_q;
    logic [SLOTS-1:0] valid_nxt;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_nxt;
    fill_state_t      state_q;
    fill_state_t      state_nxt;

    logic             stream_go;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [SLOTS-1:0] wr_onehot;

    // Load outranks Stream; a dropped Stream must not move the pointer.
    assign stream_go = stream && !load && ready && !clear;
    assign wr_en     = !clear && (load || stream_go);
    assign wr_idx    = load ? s : ptr_q;

    dec3to8 u_dec (
        .idx    (wr_idx),
        .en     (wr_en),
        .onehot (wr_onehot)
    );

    always_comb begin
        valid_nxt = valid_q;
        ptr_nxt   = ptr_q;
        if (clear) begin
            valid_nxt = '0;
            ptr_nxt   = '0;
        end else begin
            valid_nxt = valid_q | wr_onehot;
            if (stream_go) begin
                ptr_nxt = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_onehot[i]) begin
                    slot_q[i] <= d;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Derived from the post-edge valid vector, so FULL can only be left via Clear.
    always_comb begin
        state_nxt = state_from_valid(valid_nxt);
    end

    always_comb begin
        empty = 1'b0;
        full  = 1'b0;
        case (state_q)
            ST_EMPTY: empty = 1'b1;
            ST_FULL:  full  = 1'b1;
            default: ;
        endcase
        ready = !full;
    end

    assign valid = valid_q;
    assign ptr   = ptr_q;
    assign w0    = slot_q[0];
    assign w1    = slot_q[1];
    assign w2    = slot_q[2];
    assign w3    = slot_q[3];
    assign w4    = slot_q[4];
    assign w5    = slot_q[5];
    assign w6    = slot_q[6];
    assign w7    = slot_q[7];

endmodule

// File: tb/tb_demux8_4b_bank.sv
// tb/tb_demux8_4b_bank.sv - randomized and directed checks of demux8_4b_bank against a slot-array model
module tb_demux8_4b_bank;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] s = '0;
    logic [3:0] d = '0;
    logic       load = 1'b0;
    logic       stream = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [7:0] valid;
    logic [2:0] ptr;
    logic       ready, empty, full;
    logic [3:0] wv [8];

    int errors = 0;
    int checks = 0;

    int m_data [8];
    bit m_vld  [8];
    int m_ptr;

    always #5 clock = ~clock;

    demux8_4b_bank dut (
        .clock  (clock),
        .resetn (resetn),
        .s      (s),
        .d      (d),
        .load   (load),
        .stream (stream),
        .clear  (clear),
        .w0     (w0),
        .w1     (w1),
        .w2     (w2),
        .w3     (w3),
        .w4     (w4),
        .w5     (w5),
        .w6     (w6),
        .w7     (w7),
        .valid  (valid),
        .ptr    (ptr),
        .ready  (ready),
        .empty  (empty),
        .full   (full)
    );

    assign wv[0] = w0;
    assign wv[1] = w1;
    assign wv[2] = w2;
    assign wv[3] = w3;
    assign wv[4] = w4;
    assign wv[5] = w5;
    assign wv[6] = w6;
    assign wv[7] = w7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_vld[i];
        return n;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = 0;
            m_vld[i]  = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_edge(input bit rn, input bit cl, input bit ld, input bit st,
                              input int sel, input int dat);
        if (!rn || cl) begin
            model_wipe();
        end else if (ld) begin
            m_data[sel] = dat;
            m_vld[sel]  = 1;
        end else if (st && model_count() != 8) begin
            m_data[m_ptr] = dat;
            m_vld[m_ptr]  = 1;
            m_ptr = (m_ptr + 1) % 8;
        end
    endtask

    task automatic compare_all(input string ctx);
        logic [7:0] ev;
        int n;
        n = model_count();
        for (int i = 0; i < 8; i++) begin
            ev[i] = m_vld[i];
            check($sformatf("%s w%0d", ctx, i), 32'(wv[i]), 32'(m_data[i]));
        end
        check({ctx, " valid"}, 32'(valid), 32'(ev));
        check({ctx, " ptr"},   32'(ptr),   32'(m_ptr));
        check({ctx, " full"},  32'(full),  32'(n == 8));
        check({ctx, " empty"}, 32'(empty), 32'(n == 0));
        check({ctx, " ready"}, 32'(ready), 32'(n != 8));
    endtask

    task automatic step(input string ctx, input bit rn, input bit cl, input bit ld, input bit st,
                        input int sel, input int dat);
        @(negedge clock);
        resetn = rn;
        clear  = cl;
        load   = ld;
        stream = st;
        s      = 3'(sel);
        d      = 4'(dat);
        @(posedge clock);
        model_edge(rn, cl, ld, st, sel, dat);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        model_wipe();

        step("reset", 0, 0, 1, 0, 3, 4'hA);
        check("reset empty const", 32'(empty), 32'd1);
        check("reset valid const", 32'(valid), 32'h00);

        for (int i = 0; i < 8; i++) step("fill", 1, 0, 0, 1, 0, i + 1);
        check("fill full const", 32'(full), 32'd1);
        check("fill ptr wrap", 32'(ptr), 32'd0);
        step("ninth", 1, 0, 0, 1, 0, 4'hF);
        check("ninth w0 kept", 32'(w0), 32'd1);

        step("ovw full", 1, 0, 1, 0, 7, 4'hC);
        check("ovw w7", 32'(w7), 32'hC);
        check("ovw still full", 32'(full), 32'd1);
        step("clear+load", 1, 1, 1, 0, 2, 4'h5);
        check("clear valid", 32'(valid), 32'h00);

        step("pre a", 1, 0, 0, 1, 0, 4'h3);
        step("pre b", 1, 0, 0, 1, 0, 4'h4);
        step("collide", 1, 0, 1, 1, 5, 4'h9);
        check("collide w5", 32'(w5), 32'h9);
        check("collide ptr", 32'(ptr), 32'd2);
        check("collide v2", 32'(valid[2]), 32'd0);

        step("clr", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("ldfill", 1, 0, 1, 0, i, 15 - i);
        check("ldfill full", 32'(full), 32'd1);
        check("ldfill ptr", 32'(ptr), 32'd0);
        step("ld4 again", 1, 0, 1, 0, 4, 4'h1);

        step("clr2", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("midfill", 1, 0, 0, 1, 0, i + 2);
        step("midreset", 0, 0, 0, 1, 0, 4'hE);
        step("post", 1, 0, 0, 1, 0, 4'h7);
        check("post valid", 32'(valid), 32'h01);
        check("post w0", 32'(w0), 32'h7);
        check("post ptr", 32'(ptr), 32'd1);

        for (int n = 0; n < 1500; n++) begin
            step("rand",
                 $urandom_range(0, 79) != 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
